id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage that sits directly upstream of the ALU. It registers decoded operands and control fields each cycle. It resolves RAW hazards by forwarding from the MEM and WB stages, then drives the ALU's two operand inputs and control code. It also detects load-use hazards for the hazard controller and supports stall (hold) and flush (bubble insertion).

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/fwd_mux.sv | 35 +++
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: datapath widths, ALU op codes, result-source codes
// and the packed control bundle carried from decode into execute.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic [1:0] result_src;
        logic [2:0] alu_ctrl;
        logic       alu_src;
    } ctrl_t;

    // A bubble is all-zero: no side effects and ALU op defaults to add.
    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(10'd0);

endpackage

// File: rtl/fwd_mux.sv
// Per-source bypass selector: MEM result beats WB result beats the register
// value captured at decode. x0 is never bypassed.
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs_i,
    input  logic [XLEN-1:0] rs_val_i,
    input  logic [REGW-1:0] rd_m_i,
    input  logic            reg_write_m_i,
    input  logic [XLEN-1:0] alu_result_m_i,
    input  logic [REGW-1:0] rd_w_i,
    input  logic            reg_write_w_i,
    input  logic [XLEN-1:0] result_w_i,
    output logic [XLEN-1:0] fwd_o
);

    function automatic logic fwd_hit(input logic we, input logic [REGW-1:0] rd,
                                     input logic [REGW-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    // Priority bypass selection, MEM first.
    always_comb begin
        fwd_o = rs_val_i;
        if (fwd_hit(reg_write_m_i, rd_m_i, rs_i)) begin
            fwd_o = alu_result_m_i;
        end else if (fwd_hit(reg_write_w_i, rd_w_i, rs_i)) begin
            fwd_o = result_w_i;
        end else begin
            fwd_o = rs_val_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with MEM/WB operand bypass, ALU operand
// selection, stall/flush control and load-use hazard detection.
import riscv_pkg::*;

module id_ex_stage #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int REGW = riscv_pkg::REGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            Flush,
    input  logic            ValidD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic [2:0]      ALUctrlD,
    input  logic            ALUSrcD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic [1:0]      ResultSrcD,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [REGW-1:0] RdM,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [REGW-1:0] RdW,
    input  logic            RegWriteW,
    output logic [XLEN-1:0] ALUop1,
    output logic [XLEN-1:0] ALUop2,
    output logic [2:0]      ALUctrlE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [REGW-1:0] RdE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            ValidE,
    output logic [1:0]      ResultSrcE,
    output logic            LoadUseHazard
);

    ctrl_t           ctrl_d, ctrl_q;
    logic [XLEN-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q, pc_d, pc_q;
    logic [REGW-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [XLEN-1:0] fwd1_s, fwd2_s;

    // Next E state: Flush beats Stall beats a fresh load; invalid slots load as bubbles.
    always_comb begin
        ctrl_d = ctrl_q;
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        rd_d   = rd_q;
        if (Flush) begin
            ctrl_d = CTRL_BUBBLE;
            rd1_d  = '0;
            rd2_d  = '0;
            imm_d  = '0;
            pc_d   = '0;
            rs1_d  = '0;
            rs2_d  = '0;
            rd_d   = '0;
        end else if (Stall) begin
            ctrl_d = ctrl_q;
        end else begin
            ctrl_d.valid      = ValidD;
            ctrl_d.reg_write  = RegWriteD & ValidD;
            ctrl_d.mem_write  = MemWriteD & ValidD;
            ctrl_d.branch     = BranchD & ValidD;
            ctrl_d.result_src = ResultSrcD;
            ctrl_d.alu_ctrl   = ALUctrlD;
            ctrl_d.alu_src    = ALUSrcD;
            rd1_d = RD1D;
            rd2_d = RD2D;
            imm_d = ImmExtD;
            pc_d  = PCD;
            rs1_d = Rs1D;
            rs2_d = Rs2D;
            rd_d  = RdD;
        end
    end

    // E register bank with synchronous reset to the bubble state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_BUBBLE;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            pc_q   <= pc_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .rs_i(rs1_q), .rs_val_i(rd1_q),
        .rd_m_i(RdM), .reg_write_m_i(RegWriteM), .alu_result_m_i(ALUResultM),
        .rd_w_i(RdW), .reg_write_w_i(RegWriteW), .result_w_i(ResultW),
        .fwd_o(fwd1_s)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .rs_i(rs2_q), .rs_val_i(rd2_q),
        .rd_m_i(RdM), .reg_write_m_i(RegWriteM), .alu_result_m_i(ALUResultM),
        .rd_w_i(RdW), .reg_write_w_i(RegWriteW), .result_w_i(ResultW),
        .fwd_o(fwd2_s)
    );

    assign ALUop1     = fwd1_s;
    assign ALUop2     = ctrl_q.alu_src ? imm_q : fwd2_s;
    assign WriteDataE = fwd2_s;
    assign ALUctrlE   = ctrl_q.alu_ctrl;
    assign PCE        = pc_q;
    assign ImmExtE    = imm_q;
    assign RdE        = rd_q;
    assign RegWriteE  = ctrl_q.reg_write;
    assign MemWriteE  = ctrl_q.mem_write;
    assign BranchE    = ctrl_q.branch;
    assign ValidE     = ctrl_q.valid;
    assign ResultSrcE = ctrl_q.result_src;

    // Conservative: rs2 is compared even when D does not read it.
    assign LoadUseHazard = ctrl_q.valid && (ctrl_q.result_src == RES_LOAD) &&
                           (rd_q != '0) && ValidD &&
                           ((rd_q == Rs1D) || (rd_q == Rs2D));

endmodule

// File: tb/tb_id_ex_stage.sv
// Vector/scoreboard bench for id_ex_stage: each record drives D before an edge,
// M/W sources and next-D indices after it, then checks E outputs.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, Stall, Flush, ValidD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW;
    logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW;
    logic [2:0]  ALUctrlD;
    logic        ALUSrcD, RegWriteD, MemWriteD, BranchD, RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcD;
    logic [31:0] ALUop1, ALUop2, WriteDataE, PCE, ImmExtE;
    logic [2:0]  ALUctrlE;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, BranchE, ValidE, LoadUseHazard;
    logic [1:0]  ResultSrcE;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUctrlD(ALUctrlD), .ALUSrcD(ALUSrcD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD),
        .ResultSrcD(ResultSrcD), .ALUResultM(ALUResultM), .RdM(RdM),
        .RegWriteM(RegWriteM), .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrlE(ALUctrlE), .WriteDataE(WriteDataE),
        .PCE(PCE), .ImmExtE(ImmExtE), .RdE(RdE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .ValidE(ValidE),
        .ResultSrcE(ResultSrcE), .LoadUseHazard(LoadUseHazard)
    );

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  ctrl;
        logic        alusrc, rw, mw, br;
        logic [1:0]  rsrc;
        logic [4:0]  rdm, rdw, rs1n, rs2n;
        logic        rwm, rww, validn;
        logic [31:0] alum, resw;
        logic [31:0] e_op1, e_op2, e_wd, e_pc;
        logic [2:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic        e_valid, e_rw, e_mw, e_br, e_luh;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t zv();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; Stall = v.stall; Flush = v.flush; ValidD = v.valid;
        RD1D = v.rd1; RD2D = v.rd2; ImmExtD = v.imm; PCD = v.pc;
        Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd; ALUctrlD = v.ctrl; ALUSrcD = v.alusrc;
        RegWriteD = v.rw; MemWriteD = v.mw; BranchD = v.br; ResultSrcD = v.rsrc;
        sb.push_back(v);
        @(posedge clk);
        #1;
        rst = 1'b0;
        RdM = v.rdm; RegWriteM = v.rwm; ALUResultM = v.alum;
        RdW = v.rdw; RegWriteW = v.rww; ResultW = v.resw;
        Rs1D = v.rs1n; Rs2D = v.rs2n; ValidD = v.validn;
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("ALUop1", ALUop1, e.e_op1);
            chk("ALUop2", ALUop2, e.e_op2);
            chk("WriteDataE", WriteDataE, e.e_wd);
            chk("PCE", PCE, e.e_pc);
            chk("ALUctrlE", {29'd0, ALUctrlE}, {29'd0, e.e_ctrl});
            chk("RdE", {27'd0, RdE}, {27'd0, e.e_rd});
            chk("ValidE", {31'd0, ValidE}, {31'd0, e.e_valid});
            chk("RegWriteE", {31'd0, RegWriteE}, {31'd0, e.e_rw});
            chk("MemWriteE", {31'd0, MemWriteE}, {31'd0, e.e_mw});
            chk("BranchE", {31'd0, BranchE}, {31'd0, e.e_br});
            chk("LoadUseHazard", {31'd0, LoadUseHazard}, {31'd0, e.e_luh});
        end
    endtask

    vec_t v, held;

    initial begin
        rst = 1'b1; Stall = 1'b0; Flush = 1'b0; ValidD = 1'b0;
        RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0; Rs1D = '0; Rs2D = '0; RdD = '0;
        ALUctrlD = '0; ALUSrcD = 1'b0; RegWriteD = 1'b0; MemWriteD = 1'b0; BranchD = 1'b0;
        ResultSrcD = '0; ALUResultM = '0; RdM = '0; RegWriteM = 1'b0;
        ResultW = '0; RdW = '0; RegWriteW = 1'b0;
        repeat (2) @(posedge clk);

        // reset with active D inputs: bubble
        v = zv(); v.rst = 1'b1; v.valid = 1'b1; v.rw = 1'b1; v.mw = 1'b1; v.br = 1'b1;
        v.ctrl = 3'b001; v.rd1 = 32'h9; v.rs1 = 5'd3; v.rd = 5'd4; v.pc = 32'h100;
        vecs.push_back(v);
        // plain pass-through
        v = zv(); v.valid = 1'b1; v.rd1 = 32'd5; v.rd2 = 32'd7; v.rs1 = 5'd1; v.rs2 = 5'd2;
        v.rd = 5'd6; v.ctrl = 3'b001; v.rw = 1'b1; v.pc = 32'h200;
        v.e_op1 = 32'd5; v.e_op2 = 32'd7; v.e_wd = 32'd7; v.e_pc = 32'h200; v.e_ctrl = 3'b001;
        v.e_rd = 5'd6; v.e_valid = 1'b1; v.e_rw = 1'b1;
        vecs.push_back(v);
        // immediate operand
        v.imm = 32'hFFFF_FFFC; v.alusrc = 1'b1; v.ctrl = 3'b000; v.pc = 32'h204;
        v.e_op2 = 32'hFFFF_FFFC; v.e_ctrl = 3'b000; v.e_pc = 32'h204;
        vecs.push_back(v);
        // MEM and WB both match rs1: MEM wins
        v = zv(); v.valid = 1'b1; v.rs1 = 5'd3; v.rd1 = 32'hAA; v.rs2 = 5'd2; v.rd2 = 32'hBB;
        v.rd = 5'd7; v.rw = 1'b1; v.br = 1'b1; v.pc = 32'h300;
        v.rdm = 5'd3; v.rdw = 5'd3; v.rwm = 1'b1; v.rww = 1'b1; v.alum = 32'h11; v.resw = 32'h22;
        v.e_op1 = 32'h11; v.e_op2 = 32'hBB; v.e_wd = 32'hBB; v.e_pc = 32'h300;
        v.e_rd = 5'd7; v.e_valid = 1'b1; v.e_rw = 1'b1; v.e_br = 1'b1;
        vecs.push_back(v);
        v.rwm = 1'b0; v.e_op1 = 32'h22;
        vecs.push_back(v);
        v.rwm = 1'b1; v.rdm = 5'd0; v.rdw = 5'd0; v.e_op1 = 32'hAA;
        vecs.push_back(v);
        // WB forward on rs2 seen on WriteDataE while ALUop2 takes the immediate
        v = zv(); v.valid = 1'b1; v.rs1 = 5'd1; v.rd1 = 32'h1; v.rs2 = 5'd8; v.rd2 = 32'h33;
        v.imm = 32'h44; v.alusrc = 1'b1; v.rd = 5'd2; v.mw = 1'b1; v.ctrl = 3'b101;
        v.rdw = 5'd8; v.rww = 1'b1; v.resw = 32'h55; v.rdm = 5'd9; v.rwm = 1'b1; v.alum = 32'h66;
        v.e_op1 = 32'h1; v.e_op2 = 32'h44; v.e_wd = 32'h55; v.e_ctrl = 3'b101; v.e_rd = 5'd2;
        v.e_valid = 1'b1; v.e_mw = 1'b1;
        vecs.push_back(v);
        // load x4 in E, dependent rs2 in D
        v = zv(); v.valid = 1'b1; v.rsrc = 2'b01; v.rd = 5'd4; v.rw = 1'b1;
        v.rs1n = 5'd1; v.rs2n = 5'd4; v.validn = 1'b1;
        v.e_rd = 5'd4; v.e_valid = 1'b1; v.e_rw = 1'b1; v.e_luh = 1'b1;
        vecs.push_back(v);
        v.rs1n = 5'd5; v.rs2n = 5'd5; v.e_luh = 1'b0;
        vecs.push_back(v);
        v.rs1n = 5'd4; v.rs2n = 5'd4; v.validn = 1'b0;
        vecs.push_back(v);
        v.rd = 5'd0; v.rs1n = 5'd0; v.rs2n = 5'd0; v.validn = 1'b1; v.e_rd = 5'd0;
        vecs.push_back(v);
        // invalid D slot: flags suppressed, data still captured
        v = zv(); v.valid = 1'b0; v.rw = 1'b1; v.mw = 1'b1; v.br = 1'b1; v.rd1 = 32'h12;
        v.rd2 = 32'h34; v.ctrl = 3'b011; v.rd = 5'd9; v.pc = 32'h400;
        v.e_op1 = 32'h12; v.e_op2 = 32'h34; v.e_wd = 32'h34; v.e_ctrl = 3'b011; v.e_rd = 5'd9;
        v.e_pc = 32'h400;
        vecs.push_back(v);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Stall held 3 cycles while D changes; forwarding stays live
        held = zv(); held.valid = 1'b1; held.rd1 = 32'h100; held.rs1 = 5'd10;
        held.rd2 = 32'h200; held.rs2 = 5'd11; held.ctrl = 3'b010; held.rd = 5'd9;
        held.rw = 1'b1; held.mw = 1'b1; held.pc = 32'h500;
        held.e_op1 = 32'h100; held.e_op2 = 32'h200; held.e_wd = 32'h200; held.e_pc = 32'h500;
        held.e_ctrl = 3'b010; held.e_rd = 5'd9; held.e_valid = 1'b1; held.e_rw = 1'b1;
        held.e_mw = 1'b1;
        run_vec(held);
        for (int c = 0; c < 3; c++) begin
            v = held; v.stall = 1'b1; v.rd1 = 32'hDEAD; v.rs1 = 5'd12; v.ctrl = 3'b101;
            v.rd = 5'd13; v.rw = 1'b0; v.mw = 1'b0; v.pc = 32'h600;
            if (c == 1) begin
                v.rdm = 5'd10; v.rwm = 1'b1; v.alum = 32'h77; v.e_op1 = 32'h77;
            end
            run_vec(v);
        end
        // Stall and Flush together: bubble
        v = held; v.stall = 1'b1; v.flush = 1'b1;
        v.e_op1 = '0; v.e_op2 = '0; v.e_wd = '0; v.e_pc = '0; v.e_ctrl = '0; v.e_rd = '0;
        v.e_valid = 1'b0; v.e_rw = 1'b0; v.e_mw = 1'b0;
        run_vec(v);
        // rst during stall: bubble
        run_vec(held);
        v.flush = 1'b0; v.rst = 1'b1;
        run_vec(v);
        // load-use flush sequence: hazard seen, Flush clears ValidE
        v = zv(); v.valid = 1'b1; v.rsrc = 2'b01; v.rd = 5'd6; v.rw = 1'b1;
        v.rs1n = 5'd6; v.validn = 1'b1;
        v.e_rd = 5'd6; v.e_valid = 1'b1; v.e_rw = 1'b1; v.e_luh = 1'b1;
        run_vec(v);
        v = zv(); v.flush = 1'b1; v.valid = 1'b1; v.rs1 = 5'd6; v.rw = 1'b1; v.rd = 5'd3;
        run_vec(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
